// File: rtl/board_pkg.sv
// Board-level constants shared by all blocks clocked from the 133 MHz system clock.
package board_pkg;

  localparam int unsigned CLOCK_HZ = 133_000_000;

  // Convert a duration in milliseconds into system clock cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * (CLOCK_HZ / 1000);
  endfunction

  // 10 ms debounce window and 1 s long-press hold at the system clock rate.
  localparam int unsigned STABLE_CYCLES_DEFAULT = ms_to_cycles(10);
  localparam int unsigned LONG_CYCLES_DEFAULT   = ms_to_cycles(1000);

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle around one debounced push button.
// Signalling: pin_in is a raw level from the board; level is a registered
// level; fall, rise and long_press are single-cycle pulses, high for exactly
// one clock and never held, so no acknowledge is required from the consumer.
interface button_debounce_if;
  import board_pkg::*;

  logic pin_in;
  logic level;
  logic fall;
  logic rise;
  logic long_press;

  // Side that drives the pin and consumes the debounced events.
  modport master (output pin_in, input level, fall, rise, long_press);
  // Side that debounces the pin.
  modport slave  (input pin_in, output level, fall, rise, long_press);
endinterface

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for one asynchronous data bit.
module sync_ff2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer with press/release pulses and an optional long-press
// pulse. Long-press logic is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is
// defined; otherwise long_press is tied low and LONG_CYCLES is only range-checked.
module button_debounce
  import board_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic pin_in,
  output logic level,
  output logic fall,
  output logic rise,
  output logic long_press
);

  // Counter holds 0..STABLE_CYCLES-1 and clears on reaching the top, so it never wraps.
  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || LONG_CYCLES < STABLE_CYCLES) begin : g_param_check
    $error("button_debounce: need STABLE_CYCLES >= 2 and LONG_CYCLES >= STABLE_CYCLES");
  end

  logic          sync;
  logic [SW-1:0] stab_cnt;
  logic          mismatch;
  logic          stab_hit;
  logic          rise_evt;

  // The raw pin is only ever seen through this synchronizer; idle level is high.
  sync_ff2 #(.RESET_VAL(1'b1)) u_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (pin_in),
    .q      (sync)
  );

  assign mismatch = sync ^ level;
  assign stab_hit = mismatch && (stab_cnt == STABLE_MAX);
  assign rise_evt = stab_hit && sync;

  // Count consecutive mismatching cycles; any agreeing cycle restarts the window.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stab_cnt <= '0;
    end else if (!mismatch || stab_hit) begin
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Accept the new level once the mismatch has lasted the full window and flag its direction.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level <= 1'b1;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      if (stab_hit) level <= sync;
      fall <= stab_hit && !sync;
      rise <= stab_hit && sync;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_cnt;

  // Time the hold while level is low; saturating at the top gives one pulse per
  // press, and a release arriving on the same edge suppresses that pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      long_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (level) begin
        long_cnt <= '0;
      end else if (long_cnt != LONG_MAX) begin
        long_cnt <= long_cnt + 1'b1;
        if (long_cnt == LONG_PRE && !rise_evt) long_press <= 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with STABLE_CYCLES=4, LONG_CYCLES=16.
// Expectations for long_press follow BUTTON_DEBOUNCE_LONG_PRESS_EN.
module tb_button_debounce;
  localparam int S = 4;
  localparam int L = 16;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  button_debounce_if bi ();

  button_debounce #(.STABLE_CYCLES(S), .LONG_CYCLES(L)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pin_in     (bi.pin_in),
    .level      (bi.level),
    .fall       (bi.fall),
    .rise       (bi.rise),
    .long_press (bi.long_press)
  );

  // ---------------- reference model ----------------
  // Behavioural view: the pin is seen two edges late; level follows once it has
  // disagreed for S consecutive edges; a hold of L edges at level 0 fires once.
  logic [3:0] exp_q[$];   // {long_press, rise, fall, level}
  int edge_n = 0;
  int m_s1 = 1, m_sync = 1, m_level = 1, run = 0, held = 0;

  always @(posedge clock) begin
    int old_level;
    bit e_fall, e_rise, e_long;
    edge_n++;
    e_fall = 0; e_rise = 0; e_long = 0;
    if (!resetn) begin
      m_s1 = 1; m_sync = 1; m_level = 1; run = 0; held = 0;
    end else begin
      old_level = m_level;
      if (m_sync != m_level) begin
        run++;
        if (run == S) begin
          m_level = m_sync;
          run = 0;
          e_fall = (m_level == 0);
          e_rise = (m_level == 1);
        end
      end else begin
        run = 0;
      end
      if (old_level == 0) begin
        if (held < L) begin
          held++;
          if (held == L && !e_rise) e_long = 1;
        end
      end else begin
        held = 0;
      end
      m_sync = m_s1;
      m_s1 = int'(bi.pin_in);
    end
    exp_q.push_back({e_long & LP_EN, e_rise, e_fall, m_level[0]});
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int fall_cnt = 0, rise_cnt = 0, long_cnt = 0;
  int fall_edge = -1, long_edge = -1;

  // Advance one cycle: sample at the falling edge, score against the model, record pulses.
  task automatic nxt();
    logic [3:0] exp_v, got_v;
    @(negedge clock);
    got_v = {bi.long_press, bi.rise, bi.fall, bi.level};
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL scoreboard edge %0d: got long/rise/fall/level=%b expected %b",
                 edge_n, got_v, exp_v);
      end
    end
    n_cmp++;
    if ((bi.rise & bi.fall) !== 1'b0) begin
      n_err++;
      $display("FAIL rise_and_fall edge %0d: got rise=%b fall=%b expected not both", edge_n, bi.rise, bi.fall);
    end
    if (bi.fall === 1'b1) begin fall_cnt++; fall_edge = edge_n; end
    if (bi.rise === 1'b1) rise_cnt++;
    if (bi.long_press === 1'b1) begin long_cnt++; long_edge = edge_n; end
    #1;
  endtask

  // Step until a new fall pulse appears, bounded.
  task automatic wait_fall(input int f0, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      nxt();
      if (fall_cnt > f0) ok = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int f0, r0, l0;
    bi.pin_in = 1'b1;
    resetn = 1'b0;
    repeat (3) nxt();
    n_cmp++;
    if (bi.level !== 1'b1) begin
      n_err++; $display("FAIL reset_level: got %b expected 1", bi.level);
    end
    resetn = 1'b1;
    f0 = fall_cnt; r0 = rise_cnt; l0 = long_cnt;
    repeat (50) nxt();
    n_cmp++;
    if (bi.level !== 1'b1) begin
      n_err++; $display("FAIL idle_level: got %b expected 1", bi.level);
    end
    n_cmp++;
    if ((fall_cnt - f0) + (rise_cnt - r0) + (long_cnt - l0) !== 0) begin
      n_err++; $display("FAIL idle_pulses: got %0d expected 0", (fall_cnt - f0) + (rise_cnt - r0) + (long_cnt - l0));
    end
  endtask

  task automatic test_press_release();
    int f0, r0, chg;
    bit ok;
    f0 = fall_cnt; r0 = rise_cnt;
    bi.pin_in = 1'b0;
    chg = edge_n;
    wait_fall(f0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL press_timeout: got no fall expected fall within 20 cycles");
    end
    n_cmp++;
    if (fall_edge !== chg + S + 2) begin
      n_err++; $display("FAIL press_latency: got edge %0d expected %0d", fall_edge, chg + S + 2);
    end
    repeat (7) nxt();
    n_cmp++;
    if (bi.level !== 1'b0 || fall_cnt - f0 !== 1 || rise_cnt - r0 !== 0) begin
      n_err++; $display("FAIL press_state: got level=%b falls=%0d rises=%0d expected 0/1/0",
                        bi.level, fall_cnt - f0, rise_cnt - r0);
    end
    bi.pin_in = 1'b1;
    repeat (10) nxt();
    n_cmp++;
    if (bi.level !== 1'b1 || rise_cnt - r0 !== 1) begin
      n_err++; $display("FAIL release_state: got level=%b rises=%0d expected 1/1", bi.level, rise_cnt - r0);
    end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = fall_cnt;
    bi.pin_in = 1'b0;
    repeat (3) nxt();
    bi.pin_in = 1'b1;
    repeat (10) nxt();
    n_cmp++;
    if (bi.level !== 1'b1 || fall_cnt !== f0) begin
      n_err++; $display("FAIL single_glitch: got level=%b falls=%0d expected 1/0", bi.level, fall_cnt - f0);
    end
    for (int k = 0; k < 6; k++) begin
      bi.pin_in = 1'b0;
      repeat (3) nxt();
      bi.pin_in = 1'b1;
      nxt();
    end
    repeat (10) nxt();
    n_cmp++;
    if (bi.level !== 1'b1 || fall_cnt !== f0) begin
      n_err++; $display("FAIL repeated_glitch: got level=%b falls=%0d expected 1/0", bi.level, fall_cnt - f0);
    end
  endtask

  task automatic test_long_press();
    int l0, r0, exp_edge;
    l0 = long_cnt; r0 = rise_cnt;
    for (int p = 1; p <= 2; p++) begin
      bi.pin_in = 1'b0;
      repeat (40) nxt();
      exp_edge = LP_EN ? fall_edge + L : long_edge;
      n_cmp++;
      if (long_cnt - l0 !== p * int'(LP_EN)) begin
        n_err++; $display("FAIL long_count press %0d: got %0d expected %0d", p, long_cnt - l0, p * int'(LP_EN));
      end
      n_cmp++;
      if (long_edge !== exp_edge) begin
        n_err++; $display("FAIL long_latency press %0d: got edge %0d expected %0d", p, long_edge, exp_edge);
      end
      bi.pin_in = 1'b1;
      repeat (12) nxt();
      n_cmp++;
      if (rise_cnt - r0 !== p || long_cnt - l0 !== p * int'(LP_EN)) begin
        n_err++; $display("FAIL long_release press %0d: got rises=%0d longs=%0d expected %0d/%0d",
                          p, rise_cnt - r0, long_cnt - l0, p, p * int'(LP_EN));
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int f0, rel;
    bit ok;
    f0 = fall_cnt;
    bi.pin_in = 1'b0;
    repeat (3) nxt();
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (bi.level !== 1'b1 || bi.fall !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got level=%b fall=%b expected 1/0", bi.level, bi.fall);
    end
    nxt();
    resetn = 1'b1;
    rel = edge_n;
    wait_fall(f0, ok);
    n_cmp++;
    if (!ok || fall_edge !== rel + S + 2) begin
      n_err++; $display("FAIL reset_refall: got edge %0d expected %0d", fall_edge, rel + S + 2);
    end
    bi.pin_in = 1'b1;
    repeat (12) nxt();
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 40; r++) begin
      bi.pin_in = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 2 * S);
      repeat (len) nxt();
    end
    bi.pin_in = 1'b1;
    repeat (12) nxt();
    n_cmp++;
    if (bi.level !== 1'b1) begin
      n_err++; $display("FAIL random_settle: got level=%b expected 1", bi.level);
    end
  endtask

  initial begin
    bi.pin_in = 1'b1;
    test_reset();
    test_press_release();
    test_glitch();
    test_long_press();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1330000, number of consecutive clock cycles (10 ms at 133 MHz) the synchronized input must differ from the output before the output changes; legal range 2..2^24.
REQ-002 SHALL have parameter LONG_CYCLES, default 133000000, number of cycles the debounced level must stay low before a long-press pulse; legal range STABLE_CYCLES..2^31.
REQ-003 SHALL have port: clock  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: pin_in  input  1  raw, asynchronous, active-low push-button pin (idle high).
REQ-006 SHALL have port: level  output  1  debounced pin level, registered.
REQ-007 SHALL have port: fall  output  1  one-cycle pulse on the cycle level goes 1->0 (press).
REQ-008 SHALL have port: rise  output  1  one-cycle pulse on the cycle level goes 0->1 (release).
REQ-009 SHALL have port: long_press  output  1  one-cycle pulse after a press is held for LONG_CYCLES.

Function
REQ-010 SHALL pass pin_in through a two-flop synchronizer; its output, sync, is the only internal use of pin_in.
REQ-011 SHALL keep a stability counter wide enough for STABLE_CYCLES-1; it increments each cycle sync != level and clears to 0 each cycle sync == level.
REQ-012 SHALL, on the edge where the counter equals STABLE_CYCLES-1 and sync != level, load level <= sync, clear the counter, and assert fall or rise for exactly that one cycle matching the direction.
REQ-013 SHALL give latency from a stable pin_in transition to level change of exactly 2 + STABLE_CYCLES clock edges.
REQ-014 SHALL ignore any mismatch shorter than STABLE_CYCLES cycles: counter restarts from 0, level unchanged, no pulse.
REQ-015 SHALL never assert rise and fall in the same cycle; the counter SHALL never wrap.
REQ-016 SHALL keep a long counter that counts while level == 0, saturates at LONG_CYCLES, and clears when level == 1.
REQ-017 SHALL assert long_press for one cycle when the long counter reaches LONG_CYCLES; at most one pulse per press; rearmed only by a release (level back to 1).
REQ-018 SHALL, on a release on the same edge as the long counter reaching LONG_CYCLES, give priority to the release: no long_press pulse.

Reset
REQ-019 SHALL, while resetn is low, asynchronously force both synchronizer flops to 1, level to 1, rise, fall and long_press to 0, and both counters to 0.
REQ-020 SHALL, on a reset assertion mid-debounce or mid-hold, discard all progress; after release, a still-pressed pin produces fall after 2 + STABLE_CYCLES edges.

Configuration
REQ-021 SHALL use macro BUTTON_DEBOUNCE_LONG_PRESS_EN: when defined, REQ-016..REQ-018 are implemented; when undefined, the long counter is absent, long_press is tied to 0, and LONG_CYCLES is unused.

Structure
REQ-022 SHALL take default STABLE_CYCLES/LONG_CYCLES constants and the 133 MHz clock-rate constant from the shared package board_pkg.
REQ-023 SHALL place the two-flop synchronizer in sub-module sync_ff2 (one data bit, asynchronous active-low reset, reset value parameter); all other logic is inline.

Verification (bench uses STABLE_CYCLES=4, LONG_CYCLES=16, macro defined unless noted)
REQ-024 SHALL cover: pin_in held 1 through reset release -> level=1, no pulses for 50 cycles.
REQ-025 SHALL cover: pin_in 1->0 held -> fall pulses once and level=0 exactly 6 edges after the pin change; rise never pulses.
REQ-026 SHALL cover: pin_in low for 3 cycles then high (glitch) -> level stays 1, no fall; repeated glitches every 4 cycles -> still no change.
REQ-027 SHALL cover: press held 40 cycles -> long_press pulses exactly once, 16 edges after fall; release -> rise once; second 40-cycle press -> one more long_press.
REQ-028 SHALL cover: press held, resetn pulsed low for 1 cycle at cycle 3 of the hold -> level=1 during reset, fall again 6 edges after reset release.
REQ-029 SHALL cover: macro undefined, press held 40 cycles -> long_press constant 0; fall/rise timing identical to REQ-025.
